// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter: the processor
//   request port (proc_*), the VGA/framebuffer request port (vga_*) and the
//   single-port RAM side (mem_*).
//   Modports:
//     slave  - the arbiter's view (requests/mem_q in, stall/grant/read data
//              and RAM controls out)
//     master - the environment's view (requesters plus RAM model)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // Processor port
    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic              proc_wren;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_stall;
    logic              proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;
    // VGA/framebuffer port
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_wren;
    logic [DATA_W-1:0] vga_wdata;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    // RAM side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  proc_req, proc_addr, proc_wren, proc_wdata,
        output proc_stall, proc_rvalid, proc_rdata,
        input  vga_req, vga_addr, vga_wren, vga_wdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output proc_req, proc_addr, proc_wren, proc_wdata,
        input  proc_stall, proc_rvalid, proc_rdata,
        output vga_req, vga_addr, vga_wren, vga_wdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the processor (P) and the
//   VGA/framebuffer engine (V). At most one requester is granted per cycle;
//   P wins by default, but after STARVE_LIMIT consecutive contended P grants
//   V is forced through. Read data (1-cycle RAM latency) is steered back to
//   whichever port owned the previous cycle's read.
//   Ports:
//     clock - rising-edge system clock
//     reset - synchronous, active-low
//     bus   - dmem_arbiter_if.slave (proc_*, vga_*, mem_* signals)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    // rd_own_reg[0]: P read issued last cycle, rd_own_reg[1]: V read issued last cycle
    logic [1:0]       rd_own_reg, rd_own_next;
    logic             grant_p, grant_v;

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        grant_p = 1'b0;
        grant_v = 1'b0;
        if (reset) begin
            if (bus.proc_req && bus.vga_req) begin
                if (starve_cnt_reg == CNT_LIMIT) grant_v = 1'b1;
                else                             grant_p = 1'b1;
            end else if (bus.proc_req) begin
                grant_p = 1'b1;
            end else if (bus.vga_req) begin
                grant_v = 1'b1;
            end
        end
    end

    // Counts contended cycles lost by V; any V grant or V going idle clears it.
    // Cannot pass CNT_LIMIT because reaching it forces the V grant next cycle.
    always_comb begin
        starve_cnt_next = '0;
        if (grant_p && bus.vga_req) starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end

    always_comb begin
        rd_own_next = {grant_v & ~bus.vga_wren, grant_p & ~bus.proc_wren};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
            rd_own_reg     <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rd_own_reg     <= rd_own_next;
        end
    end

    // RAM side mux; idle bus drives zeros so the RAM never sees a stray write.
    always_comb begin
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        if (grant_p) begin
            bus.mem_address = bus.proc_addr;
            bus.mem_data    = bus.proc_wdata;
            bus.mem_wren    = bus.proc_wren;
        end else if (grant_v) begin
            bus.mem_address = bus.vga_addr;
            bus.mem_data    = bus.vga_wdata;
            bus.mem_wren    = bus.vga_wren;
        end
    end

    assign bus.proc_stall = reset & bus.proc_req & ~grant_p;
    assign bus.vga_gnt    = grant_v;

    // Returns are also gated by reset so that a read granted just before
    // reset asserts never reports valid data.
    assign bus.proc_rvalid = rd_own_reg[0] & reset;
    assign bus.vga_rvalid  = rd_own_reg[1] & reset;
    assign bus.proc_rdata  = bus.proc_rvalid ? bus.mem_q : '0;
    assign bus.vga_rdata   = bus.vga_rvalid  ? bus.mem_q : '0;
endmodule
